// File: rtl/switch_pkg.sv
// Shared definitions for the switch output-port arbiter slice.
// Holds the arbiter state encoding, port index width, packet field widths
// and a small wrap-around port index helper used by the arbiter and picker.
package switch_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TX    = 2'd2
  } arb_state_t;

  localparam int PORT_IDX_W = 2;

  // Packet fields carried through the output data mux
  localparam int SRC_W  = 4;
  localparam int TGT_W  = 4;
  localparam int DATA_W = 8;
  localparam int PKT_W  = SRC_W + TGT_W + DATA_W;

  typedef struct packed {
    logic [SRC_W-1:0]  source;
    logic [TGT_W-1:0]  target;
    logic [DATA_W-1:0] data;
  } pkt_t;

  // Port index addition with natural 2-bit wrap (3 + 1 -> 0)
  function automatic logic [PORT_IDX_W-1:0] port_add(
    input logic [PORT_IDX_W-1:0] base,
    input logic [PORT_IDX_W-1:0] offset
  );
    return base + offset;
  endfunction

endpackage

// File: rtl/switch_out_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Searches req cyclically starting at ptr (ptr, ptr+1, ... mod 4) and returns
// the first requesting port.
//   req     in  4  request vector
//   ptr     in  2  search start index (round-robin pointer)
//   winner  out 2  first requesting index at or after ptr; ptr when no request
//   any_req out 1  at least one request bit is set
module rr_pick
  import switch_pkg::*;
(
  input  logic [3:0]            req,
  input  logic [PORT_IDX_W-1:0] ptr,
  output logic [PORT_IDX_W-1:0] winner,
  output logic                  any_req
);

  logic                  found_s;
  logic [PORT_IDX_W-1:0] idx_s;

  // Cyclic first-one search; the found flag keeps the earliest hit
  always_comb begin
    winner  = ptr;
    found_s = 1'b0;
    idx_s   = ptr;
    any_req = |req;
    for (int k = 0; k < 4; k++) begin
      idx_s = port_add(ptr, PORT_IDX_W'(k));
      if (!found_s && req[idx_s]) begin
        winner  = idx_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Per-output-port round-robin arbiter.
// Picks one of the 4 ingress FIFOs whose head packet targets this output,
// pops it with a one-cycle grant, holds the output mux select and presents
// the packet downstream until out_ready, or drops it after TIMEOUT stalled
// TX cycles. Every output is a flop; nothing combinational from req or
// out_ready reaches a port.
//   clk        in  1  clock
//   rst_n      in  1  asynchronous active-low reset
//   req        in  4  head-of-line request from ingress FIFO i
//   out_ready  in  1  downstream accepts the presented packet
//   grant      out 4  one-hot single-cycle pop to ingress FIFO i
//   mux_select out 2  ingress port driving the output data mux
//   valid_out  out 1  muxed packet is valid (TX state)
//   busy       out 1  arbiter is in GRANT or TX
//   drop       out 1  one-cycle pulse: packet discarded on timeout. Because it
//                     is registered, it shows in the cycle right after the
//                     last TX cycle (the first IDLE cycle).
module switch_out_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_PORTS-1:0]  req,
  input  logic                  out_ready,
  output logic [NUM_PORTS-1:0]  grant,
  output logic [PORT_IDX_W-1:0] mux_select,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  drop
);

  localparam logic             TMO_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t            state_r, state_s;
  logic [PORT_IDX_W-1:0] rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic [PORT_IDX_W-1:0] sel_s;
  logic [PORT_IDX_W-1:0] winner_s;
  logic                  any_req_s;
  logic                  drop_s;
  logic [NUM_PORTS-1:0]  grant_s;

  rr_pick u_rr_pick (
    .req     (req),
    .ptr     (rr_ptr_r),
    .winner  (winner_s),
    .any_req (any_req_s)
  );

  // Next-state, pointer, timeout counter and next-output decode
  always_comb begin
    state_s  = state_r;
    rr_ptr_s = rr_ptr_r;
    cnt_s    = cnt_r;
    sel_s    = mux_select;
    drop_s   = 1'b0;
    grant_s  = {NUM_PORTS{1'b0}};
    case (state_r)
      ARB_IDLE: begin
        if (any_req_s) begin
          sel_s   = winner_s;
          state_s = ARB_GRANT;
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_GRANT: begin
        cnt_s   = {CNT_W{1'b0}};
        state_s = ARB_TX;
      end
      ARB_TX: begin
        // Completion wins over a timeout expiring in the same cycle
        if (out_ready) begin
          rr_ptr_s = port_add(mux_select, 2'd1);
          state_s  = ARB_IDLE;
        end else if (TMO_EN && (cnt_r == TMO_LAST)) begin
          rr_ptr_s = port_add(mux_select, 2'd1);
          drop_s   = 1'b1;
          state_s  = ARB_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
    if (state_s == ARB_GRANT) begin
      grant_s[sel_s] = 1'b1;
    end else begin
      grant_s = {NUM_PORTS{1'b0}};
    end
  end

  // State, pointer, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ARB_IDLE;
      rr_ptr_r   <= 2'd0;
      cnt_r      <= {CNT_W{1'b0}};
      mux_select <= 2'd0;
      grant      <= {NUM_PORTS{1'b0}};
      valid_out  <= 1'b0;
      busy       <= 1'b0;
      drop       <= 1'b0;
    end else begin
      state_r    <= state_s;
      rr_ptr_r   <= rr_ptr_s;
      cnt_r      <= cnt_s;
      mux_select <= sel_s;
      grant      <= grant_s;
      valid_out  <= (state_s == ARB_TX);
      busy       <= (state_s != ARB_IDLE);
      drop       <= drop_s;
    end
  end

endmodule
